// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - Digit load/shift/blank controls and scan outputs of seg7_scan_driver.
// paf_mode is present only when SEG7_PAF_EN is defined.
interface seg7_scan_driver_if #(
  parameter int NDIGITS   = 4,
  parameter int CODE_BITS = 6
);
  localparam int IDX_W = $clog2(NDIGITS);

  logic                 wr_en;
  logic [IDX_W-1:0]     wr_addr;
  logic [CODE_BITS-1:0] wr_code;
  logic                 wr_dp;
  logic                 shift_en;
  logic                 blank;
`ifdef SEG7_PAF_EN
  logic                 paf_mode;
`endif
  logic [7:0]           SEG;
  logic [NDIGITS-1:0]   AN;
  logic [IDX_W-1:0]     scan_idx;

`ifdef SEG7_PAF_EN
  modport master (
    output wr_en, wr_addr, wr_code, wr_dp, shift_en, blank, paf_mode,
    input  SEG, AN, scan_idx
  );
  modport slave (
    input  wr_en, wr_addr, wr_code, wr_dp, shift_en, blank, paf_mode,
    output SEG, AN, scan_idx
  );
`else
  modport master (
    output wr_en, wr_addr, wr_code, wr_dp, shift_en, blank,
    input  SEG, AN, scan_idx
  );
  modport slave (
    input  wr_en, wr_addr, wr_code, wr_dp, shift_en, blank,
    output SEG, AN, scan_idx
  );
`endif
endinterface

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - Time-multiplexed multi-digit 7-segment driver with digit register file.
// Define SEG7_PAF_EN to add the paf_mode input (P/F/A glyph remap).
module seg7_scan_driver #(
  parameter int NDIGITS   = 4,
  parameter int CODE_BITS = 6,
  parameter int SCAN_DIV  = 1000
) (
  input  logic              clk_2,
  input  logic              reset,
  seg7_scan_driver_if.slave bus
);
  localparam int IDX_W = $clog2(NDIGITS);
  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam logic [IDX_W-1:0]     LAST_IDX   = IDX_W'(NDIGITS - 1);
  localparam logic [IDX_W:0]       NDIG_W     = (IDX_W + 1)'(NDIGITS);
  localparam logic [PRE_W-1:0]     LAST_PRE   = PRE_W'(SCAN_DIV - 1);
  localparam logic [CODE_BITS-1:0] BLANK_CODE = '1;
  localparam logic [NDIGITS-1:0]   AN_ONE     = NDIGITS'(1);

  // Each entry is {dp, code}.
  logic [CODE_BITS:0]   digit_q [NDIGITS];
  logic [PRE_W-1:0]     presc_q;
  logic [IDX_W-1:0]     scan_idx_q;
  logic [7:0]           seg_q;
  logic [NDIGITS-1:0]   an_q;
  logic [CODE_BITS:0]   cur_digit;
  logic                 addr_ok;
  logic                 paf;

`ifdef SEG7_PAF_EN
  assign paf = bus.paf_mode;
`else
  assign paf = 1'b0;
`endif

  function automatic logic [6:0] glyph(input logic [5:0] code, input logic paf_on);
    logic [6:0] g;
    g = 7'h40;
    if (paf_on) begin
      if (code <= 6'd3)       g = 7'h73;
      else if (code <= 6'd6)  g = 7'h71;
      else if (code <= 6'd9)  g = 7'h77;
      else if (code == 6'd63) g = 7'h00;
    end else begin
      case (code)
        6'd0:  g = 7'h3F;  6'd1:  g = 7'h06;  6'd2:  g = 7'h5B;  6'd3:  g = 7'h4F;
        6'd4:  g = 7'h66;  6'd5:  g = 7'h6D;  6'd6:  g = 7'h7D;  6'd7:  g = 7'h07;
        6'd8:  g = 7'h7F;  6'd9:  g = 7'h6F;  6'd10: g = 7'h77;  6'd11: g = 7'h7C;
        6'd12: g = 7'h39;  6'd13: g = 7'h5E;  6'd14: g = 7'h79;  6'd15: g = 7'h71;
        // Letter table: A b C c d E F g H h I i J L n O o P q r S t U u y degree
        6'd16: g = 7'h77;  6'd17: g = 7'h7C;  6'd18: g = 7'h39;  6'd19: g = 7'h58;
        6'd20: g = 7'h5E;  6'd21: g = 7'h79;  6'd22: g = 7'h71;  6'd23: g = 7'h6F;
        6'd24: g = 7'h76;  6'd25: g = 7'h74;  6'd26: g = 7'h06;  6'd27: g = 7'h04;
        6'd28: g = 7'h1E;  6'd29: g = 7'h38;  6'd30: g = 7'h54;  6'd31: g = 7'h3F;
        6'd32: g = 7'h5C;  6'd33: g = 7'h73;  6'd34: g = 7'h67;  6'd35: g = 7'h50;
        6'd36: g = 7'h6D;  6'd37: g = 7'h78;  6'd38: g = 7'h3E;  6'd39: g = 7'h1C;
        6'd40: g = 7'h6E;  6'd41: g = 7'h63;  6'd63: g = 7'h00;
        default: g = 7'h40;
      endcase
    end
    return g;
  endfunction

  assign addr_ok   = {1'b0, bus.wr_addr} < NDIG_W;
  assign cur_digit = digit_q[scan_idx_q];

  // Shift has priority over a same-cycle random-access write.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NDIGITS; i++) digit_q[i] <= {1'b0, BLANK_CODE};
    end else if (bus.shift_en) begin
      for (int i = NDIGITS - 1; i > 0; i--) digit_q[i] <= digit_q[i-1];
      digit_q[0] <= {bus.wr_dp, bus.wr_code};
    end else if (bus.wr_en && addr_ok) begin
      digit_q[bus.wr_addr] <= {bus.wr_dp, bus.wr_code};
    end
  end

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      presc_q    <= '0;
      scan_idx_q <= '0;
      seg_q      <= 8'h00;
      an_q       <= '0;
    end else begin
      if (presc_q == LAST_PRE) begin
        presc_q    <= '0;
        scan_idx_q <= (scan_idx_q == LAST_IDX) ? '0 : scan_idx_q + 1'b1;
      end else begin
        presc_q <= presc_q + 1'b1;
      end
      // Blank only gates the output register; scanning keeps running underneath.
      if (bus.blank) begin
        seg_q <= 8'h00;
        an_q  <= '0;
      end else begin
        an_q  <= AN_ONE << scan_idx_q;
        seg_q <= {cur_digit[CODE_BITS], glyph(cur_digit[CODE_BITS-1:0], paf)};
      end
    end
  end

  assign bus.SEG      = seg_q;
  assign bus.AN       = an_q;
  assign bus.scan_idx = scan_idx_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - Scoreboard bench for seg7_scan_driver against a behavioural display model.
// Exercises the SEG7_PAF_EN remap when that macro is defined.
module tb_seg7_scan_driver;
  localparam int NDIG = 4;
  localparam int CB   = 6;
  localparam int DIV  = 4;
  localparam int IW   = $clog2(NDIG);

  typedef struct packed {
    logic [7:0]      seg;
    logic [NDIG-1:0] an;
    logic [IW-1:0]   idx;
  } exp_t;

  logic clk_2 = 1'b0;
  logic reset = 1'b0;
  logic paf   = 1'b0;
  int   checks = 0;
  int   errors = 0;

  exp_t   sb_q[$];
  logic [6:0] mdig [NDIG];
  longint n_edges = 0;
  string  tbl [42];

  seg7_scan_driver_if #(.NDIGITS(NDIG), .CODE_BITS(CB)) bus ();

`ifdef SEG7_PAF_EN
  assign bus.paf_mode = paf;
`endif

  seg7_scan_driver #(.NDIGITS(NDIG), .CODE_BITS(CB), .SCAN_DIV(DIV)) dut (
    .clk_2 (clk_2),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk_2 = ~clk_2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Segments named by letter a..g, as on a datasheet drawing.
  function automatic logic [6:0] segs_of(input string s);
    logic [6:0] b;
    b = '0;
    for (int i = 0; i < s.len(); i++) b[int'(s[i]) - 97] = 1'b1;
    return b;
  endfunction

  function automatic logic [6:0] ref_glyph(input int code, input logic paf_on);
    if (code == 63) return 7'h00;
    if (paf_on) begin
      if (code < 4)  return segs_of("abefg");
      if (code < 7)  return segs_of("aefg");
      if (code < 10) return segs_of("abcefg");
      return segs_of("g");
    end
    if (code < 42) return segs_of(tbl[code]);
    return segs_of("g");
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NDIG; i++) mdig[i] = {1'b0, 6'd63};
    n_edges = 0;
    sb_q.delete();
  endfunction

  // Reference model: the scanned digit is simply (edges since reset / SCAN_DIV) mod NDIGITS.
  initial forever begin
    @(posedge clk_2);
    if (!reset) begin
      exp_t e;
      int   idx;
      idx = int'((n_edges / DIV) % NDIG);
      if (bus.blank) begin
        e.seg = 8'h00;
        e.an  = '0;
      end else begin
        e.an  = NDIG'(1) << idx;
        e.seg = {mdig[idx][6], ref_glyph(int'(mdig[idx][5:0]), paf)};
      end
      e.idx = IW'(((n_edges + 1) / DIV) % NDIG);
      sb_q.push_back(e);
      if (bus.shift_en) begin
        for (int i = NDIG - 1; i > 0; i--) mdig[i] = mdig[i-1];
        mdig[0] = {bus.wr_dp, bus.wr_code};
      end else if (bus.wr_en && int'(bus.wr_addr) < NDIG) begin
        mdig[int'(bus.wr_addr)] = {bus.wr_dp, bus.wr_code};
      end
      n_edges++;
    end
  end

  initial forever begin
    @(negedge clk_2);
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk("SEG", 32'(bus.SEG), 32'(e.seg));
      chk("AN", 32'(bus.AN), 32'(e.an));
      chk("scan_idx", 32'(bus.scan_idx), 32'(e.idx));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk_2);
  endtask

  task automatic write_digit(input int a, input int c, input logic dp);
    bus.wr_en = 1'b1; bus.wr_addr = IW'(a); bus.wr_code = CB'(c); bus.wr_dp = dp;
    @(negedge clk_2);
    bus.wr_en = 1'b0;
  endtask

  task automatic shift_in(input int c, input logic dp);
    bus.shift_en = 1'b1; bus.wr_code = CB'(c); bus.wr_dp = dp;
    @(negedge clk_2);
    bus.shift_en = 1'b0;
  endtask

  task automatic reset_pulse();
    @(negedge clk_2);
    #2 reset = 1'b1;
    #1;
    chk("reset_SEG", 32'(bus.SEG), 32'h00);
    chk("reset_AN", 32'(bus.AN), 32'h0);
    chk("reset_scan_idx", 32'(bus.scan_idx), 32'h0);
    model_reset();
    idle(2);
    reset = 1'b0;
  endtask

  initial begin
    tbl = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
            "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg",
            "abcefg", "cdefg", "adef", "deg", "bcdeg", "adefg", "aefg", "abcdfg",
            "bcefg", "cefg", "bc", "c", "bcde", "def", "ceg", "abcdef",
            "cdeg", "abefg", "abcfg", "eg", "acdfg", "defg", "bcdef", "cde",
            "bcdfg", "abfg"};
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_code = '0; bus.wr_dp = 1'b0;
    bus.shift_en = 1'b0; bus.blank = 1'b0;
    model_reset();
    #1 reset = 1'b1;
    #2;
    chk("por_SEG", 32'(bus.SEG), 32'h00);
    chk("por_AN", 32'(bus.AN), 32'h0);
    idle(3);
    reset = 1'b0;
    idle(6);

    for (int a = 0; a < NDIG; a++) write_digit(a, (a == 0) ? 1 : (a == 1) ? 2 : (a == 2) ? 10 : 33, 1'b0);
    idle(20);

    reset_pulse();
    idle(5);

    shift_in(24, 1'b0); shift_in(21, 1'b0); shift_in(29, 1'b1); shift_in(31, 1'b0);
    idle(18);
    shift_in(63, 1'b0);
    idle(18);

    bus.wr_en = 1'b1; bus.wr_addr = IW'(2); bus.wr_code = CB'(5);
    bus.shift_en = 1'b1; bus.wr_dp = 1'b1;
    @(negedge clk_2);
    bus.wr_en = 1'b0; bus.shift_en = 1'b0;
    idle(18);

    bus.blank = 1'b1;
    idle(10);
    bus.blank = 1'b0;
    idle(10);

    for (int k = 0; k < 400; k++) begin
      bus.wr_en    = ($urandom_range(0, 3) == 0);
      bus.shift_en = ($urandom_range(0, 7) == 0);
      bus.blank    = ($urandom_range(0, 9) == 0);
      bus.wr_addr  = IW'($urandom_range(0, NDIG - 1));
      bus.wr_code  = CB'($urandom_range(0, 63));
      bus.wr_dp    = 1'($urandom_range(0, 1));
      @(negedge clk_2);
    end
    bus.wr_en = 1'b0; bus.shift_en = 1'b0; bus.blank = 1'b0;
    idle(20);

`ifdef SEG7_PAF_EN
    paf = 1'b1;
    write_digit(0, 2, 1'b0); write_digit(1, 5, 1'b0); write_digit(2, 8, 1'b0); write_digit(3, 12, 1'b0);
    idle(20);
    write_digit(1, 63, 1'b1);
    idle(16);
    for (int k = 0; k < 200; k++) begin
      paf          = ($urandom_range(0, 3) != 0);
      bus.wr_en    = ($urandom_range(0, 2) == 0);
      bus.wr_addr  = IW'($urandom_range(0, NDIG - 1));
      bus.wr_code  = CB'($urandom_range(0, 63));
      bus.wr_dp    = 1'($urandom_range(0, 1));
      @(negedge clk_2);
    end
    bus.wr_en = 1'b0;
    paf = 1'b0;
    idle(8);
`endif

    #2;
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
